// File: rtl/game_pkg.sv
// Shared types for the turn sequencer: cell encodings, sequencer states
// and board geometry.
package game_pkg;

    localparam int NUM_CELLS = 9;
    localparam int CELL_W    = 2;
    localparam int BOARD_W   = NUM_CELLS * CELL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        COMMIT = 3'd2,
        AUTO   = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: a clock prescaler producing one tick per second and a
// seconds down-counter. expire flags the cycle in which the count hits zero.
module turn_timer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic       run,
    output logic [3:0] secs_left,
    output logic       expire
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLK_HZ - 1);
    localparam logic [3:0]    SECS_RELOAD  = 4'(TURN_SECONDS);

    logic [PW-1:0] presc_reg;
    logic [3:0]    secs_reg;
    logic          presc_zero;

    assign presc_zero = (presc_reg == '0);
    // Combinational so the sequencer can leave ARMED on the same edge that
    // takes the seconds count to zero.
    assign expire     = run && presc_zero && (secs_reg == 4'd1);
    assign secs_left  = secs_reg;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            presc_reg <= '0;
            secs_reg  <= '0;
        end else if (load) begin
            presc_reg <= PRESC_RELOAD;
            secs_reg  <= SECS_RELOAD;
        end else if (run) begin
            if (presc_zero) begin
                presc_reg <= PRESC_RELOAD;
                if (secs_reg != 4'd0)
                    secs_reg <= secs_reg - 4'd1;
            end else begin
                presc_reg <= presc_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_move_sequencer.sv
// Per-turn controller: owns the 3x3 board and turn countdown, commits manual
// moves on confirm, auto-places on timeout, and pulses the game FSM.
module turn_move_sequencer
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                turn_p1,
    input  logic                turn_p2,
    input  logic [3:0]          cell_sel,
    input  logic                confirm,
    input  logic                clear_board,
    output logic [BOARD_W-1:0]  board,
    output logic                player_mov,
    output logic                timer_out,
    output logic                move_err,
    output logic [3:0]          secs_left
);

    seq_state_t state_reg, state_next;
    cell_t      owner_reg, owner_next;
    cell_t      owner_now;
    logic [3:0] cell_reg, cell_next;
    logic       confirm_q_reg;
    logic       player_mov_reg, player_mov_next;
    logic       timer_out_reg, timer_out_next;
    logic       move_err_reg, move_err_next;

    logic             active;
    logic             confirm_rise;
    logic             sel_ok;
    logic [4:0]       free_info;
    logic             write_en;
    logic [3:0]       write_idx;
    logic             timer_load, timer_run, timer_clr, expire;
    logic [BOARD_W-1:0] board_vec;

    // Cell contents at idx; out-of-range indices read as EMPTY so callers
    // must range-check separately.
    function automatic cell_t cell_at(input logic [BOARD_W-1:0] vec, input logic [3:0] idx);
        cell_t r;
        r = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i))
                r = cell_t'(vec[CELL_W*i +: CELL_W]);
        end
        return r;
    endfunction

    // {found, index} of the lowest-index empty cell.
    function automatic logic [4:0] first_free(input logic [BOARD_W-1:0] vec);
        logic [4:0] r;
        r = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (vec[CELL_W*i +: CELL_W] == EMPTY)
                r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign active       = turn_p1 ^ turn_p2;
    assign owner_now    = turn_p1 ? P1 : P2;
    assign confirm_rise = confirm && !confirm_q_reg;
    assign sel_ok       = (cell_sel <= 4'd8) && (cell_at(board_vec, cell_sel) == EMPTY);
    assign free_info    = first_free(board_vec);

    turn_timer #(
        .CLK_HZ       (CLK_HZ),
        .TURN_SECONDS (TURN_SECONDS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr),
        .load      (timer_load),
        .run       (timer_run),
        .secs_left (secs_left),
        .expire    (expire)
    );

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        cell_next       = cell_reg;
        player_mov_next = 1'b0;
        timer_out_next  = 1'b0;
        move_err_next   = 1'b0;
        write_en        = 1'b0;
        write_idx       = cell_reg;
        timer_load      = 1'b0;
        timer_run       = 1'b0;
        timer_clr       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (active) begin
                    state_next = ARMED;
                    owner_next = owner_now;
                    timer_load = 1'b1;
                end else begin
                    timer_clr  = 1'b1;
                end
            end
            ARMED: begin
                timer_run = 1'b1;
                if (!active) begin
                    state_next = IDLE;
                    timer_clr  = 1'b1;
                end else if (confirm_rise && sel_ok) begin
                    // A valid move beats a simultaneous expiry.
                    state_next = COMMIT;
                    cell_next  = cell_sel;
                end else begin
                    if (expire)
                        state_next = AUTO;
                    if (confirm_rise)
                        move_err_next = 1'b1;
                end
            end
            COMMIT: begin
                write_en        = 1'b1;
                write_idx       = cell_reg;
                player_mov_next = 1'b1;
                state_next      = DONE;
            end
            AUTO: begin
                write_en       = free_info[4];
                write_idx      = free_info[3:0];
                timer_out_next = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (!active) begin
                    state_next = IDLE;
                    timer_clr  = 1'b1;
                end else if (owner_now != owner_reg) begin
                    state_next = ARMED;
                    owner_next = owner_now;
                    timer_load = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_clr  = 1'b1;
            end
        endcase

        if (clear_board) begin
            state_next      = IDLE;
            player_mov_next = 1'b0;
            timer_out_next  = 1'b0;
            move_err_next   = 1'b0;
            write_en        = 1'b0;
            timer_load      = 1'b0;
            timer_clr       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= EMPTY;
            cell_reg       <= '0;
            confirm_q_reg  <= 1'b0;
            player_mov_reg <= 1'b0;
            timer_out_reg  <= 1'b0;
            move_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            cell_reg       <= cell_next;
            confirm_q_reg  <= confirm;
            player_mov_reg <= player_mov_next;
            timer_out_reg  <= timer_out_next;
            move_err_reg   <= move_err_next;
        end
    end

    // One register per cell; clear_board wins over a same-cycle write.
    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            cell_t cell_q;
            always_ff @(posedge clk) begin
                if (!rst || clear_board)
                    cell_q <= EMPTY;
                else if (write_en && (write_idx == 4'(gi)))
                    cell_q <= owner_reg;
            end
            assign board_vec[CELL_W*gi +: CELL_W] = cell_q;
        end
    endgenerate

    assign board      = board_vec;
    assign player_mov = player_mov_reg;
    assign timer_out  = timer_out_reg;
    assign move_err   = move_err_reg;

endmodule

// File: tb/tb_turn_move_sequencer.sv
// Directed bench for turn_move_sequencer with CLK_HZ=4, TURN_SECONDS=3
// (12 cycles per turn); expected values are hand-computed constants.
module tb_turn_move_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        turn_p1 = 1'b0;
    logic        turn_p2 = 1'b0;
    logic [3:0]  cell_sel = 4'd0;
    logic        confirm = 1'b0;
    logic        clear_board = 1'b0;
    logic [17:0] board;
    logic        player_mov;
    logic        timer_out;
    logic        move_err;
    logic [3:0]  secs_left;

    int checks = 0;
    int errors = 0;

    turn_move_sequencer #(
        .CLK_HZ       (4),
        .TURN_SECONDS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .turn_p1     (turn_p1),
        .turn_p2     (turn_p2),
        .cell_sel    (cell_sel),
        .confirm     (confirm),
        .clear_board (clear_board),
        .board       (board),
        .player_mov  (player_mov),
        .timer_out   (timer_out),
        .move_err    (move_err),
        .secs_left   (secs_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a turn for the given player from DONE/IDLE and commits one move.
    task automatic do_move(input bit p1, input logic [3:0] c, output logic pm_seen);
        turn_p1 = p1;
        turn_p2 = !p1;
        tick;
        cell_sel = c;
        confirm  = 1'b1;
        tick;
        confirm  = 1'b0;
        tick;
        pm_seen  = player_mov;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick;
        tick;
        checks++; if (board !== 18'h0) begin errors++; $display("FAIL reset_board got %h want %h", board, 18'h0); end
        checks++; if (secs_left !== 4'd0) begin errors++; $display("FAIL reset_secs got %0d want 0", secs_left); end
        checks++; if ({player_mov, timer_out, move_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {player_mov, timer_out, move_err}); end
        rst = 1'b1;
        turn_p1 = 1'b1;
        tick;
        checks++; if (secs_left !== 4'd3) begin errors++; $display("FAIL armed_secs got %0d want 3", secs_left); end
        checks++; if (board !== 18'h0) begin errors++; $display("FAIL armed_board got %h want %h", board, 18'h0); end
        checks++; if ({player_mov, timer_out, move_err} !== 3'b000) begin errors++; $display("FAIL armed_pulses got %b want 000", {player_mov, timer_out, move_err}); end
        $display("test_reset done");
    endtask

    task automatic test_commit;
        cell_sel = 4'd4;
        confirm  = 1'b1;
        tick;
        checks++; if (player_mov !== 1'b0 || board !== 18'h0) begin errors++; $display("FAIL commit_early got pm=%b board=%h want pm=0 board=0", player_mov, board); end
        tick;
        checks++; if (board !== 18'h00100) begin errors++; $display("FAIL commit_board got %h want %h", board, 18'h00100); end
        checks++; if (player_mov !== 1'b1) begin errors++; $display("FAIL commit_pulse got %b want 1", player_mov); end
        tick;
        checks++; if (player_mov !== 1'b0) begin errors++; $display("FAIL commit_pulse_width got %b want 0", player_mov); end
        confirm = 1'b0;
        turn_p1 = 1'b0;
        turn_p2 = 1'b1;
        tick;
        checks++; if (secs_left !== 4'd3) begin errors++; $display("FAIL reload_secs got %0d want 3", secs_left); end
        $display("test_commit done");
    endtask

    task automatic test_move_err;
        cell_sel = 4'd4;
        confirm  = 1'b1;
        tick;
        checks++; if (move_err !== 1'b1) begin errors++; $display("FAIL err_occupied got %b want 1", move_err); end
        checks++; if (board !== 18'h00100) begin errors++; $display("FAIL err_board got %h want %h", board, 18'h00100); end
        tick;
        checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL err_width got %b want 0", move_err); end
        confirm = 1'b0;
        tick;
        cell_sel = 4'd12;
        confirm  = 1'b1;
        tick;
        checks++; if (move_err !== 1'b1) begin errors++; $display("FAIL err_range got %b want 1", move_err); end
        checks++; if (secs_left !== 4'd2) begin errors++; $display("FAIL err_secs got %0d want 2", secs_left); end
        checks++; if (board !== 18'h00100) begin errors++; $display("FAIL err_range_board got %h want %h", board, 18'h00100); end
        confirm = 1'b0;
        tick;
        checks++; if (move_err !== 1'b0) begin errors++; $display("FAIL err_range_width got %b want 0", move_err); end
        $display("test_move_err done");
    endtask

    task automatic test_back_to_back;
        logic pm;
        do_move(1'b0, 4'd0, pm);
        checks++; if (pm !== 1'b1 || board !== 18'h00102) begin errors++; $display("FAIL b2b_p2 got pm=%b board=%h want pm=1 board=%h", pm, board, 18'h00102); end
        do_move(1'b1, 4'd1, pm);
        checks++; if (pm !== 1'b1 || board !== 18'h00106) begin errors++; $display("FAIL b2b_p1 got pm=%b board=%h want pm=1 board=%h", pm, board, 18'h00106); end
        $display("test_back_to_back done");
    endtask

    task automatic test_timeout;
        turn_p1 = 1'b0;
        turn_p2 = 1'b1;
        tick;
        checks++; if (secs_left !== 4'd3) begin errors++; $display("FAIL to_start got %0d want 3", secs_left); end
        for (int k = 1; k <= 12; k++) begin
            tick;
            checks++; if (secs_left !== 4'(3 - k / 4) || timer_out !== 1'b0) begin errors++; $display("FAIL to_count k=%0d got secs=%0d to=%b want secs=%0d to=0", k, secs_left, timer_out, 3 - k / 4); end
        end
        tick;
        checks++; if (timer_out !== 1'b1 || player_mov !== 1'b0) begin errors++; $display("FAIL to_pulse got to=%b pm=%b want to=1 pm=0", timer_out, player_mov); end
        checks++; if (board !== 18'h00126) begin errors++; $display("FAIL to_board got %h want %h", board, 18'h00126); end
        tick;
        checks++; if (timer_out !== 1'b0 || secs_left !== 4'd0) begin errors++; $display("FAIL to_after got to=%b secs=%0d want to=0 secs=0", timer_out, secs_left); end
        $display("test_timeout done");
    endtask

    task automatic test_full_board;
        logic pm;
        do_move(1'b1, 4'd3, pm);
        do_move(1'b0, 4'd5, pm);
        do_move(1'b1, 4'd6, pm);
        do_move(1'b0, 4'd7, pm);
        do_move(1'b1, 4'd8, pm);
        checks++; if (pm !== 1'b1 || board !== 18'h19966) begin errors++; $display("FAIL full_fill got pm=%b board=%h want pm=1 board=%h", pm, board, 18'h19966); end
        turn_p1 = 1'b0;
        turn_p2 = 1'b1;
        tick;
        for (int k = 1; k <= 12; k++) tick;
        tick;
        checks++; if (timer_out !== 1'b1 || board !== 18'h19966) begin errors++; $display("FAIL full_timeout got to=%b board=%h want to=1 board=%h", timer_out, board, 18'h19966); end
        tick;
        checks++; if (timer_out !== 1'b0) begin errors++; $display("FAIL full_width got %b want 0", timer_out); end
        $display("test_full_board done");
    endtask

    task automatic test_confirm_on_expiry;
        clear_board = 1'b1;
        tick;
        checks++; if (board !== 18'h0 || secs_left !== 4'd0) begin errors++; $display("FAIL exp_clear got board=%h secs=%0d want 0/0", board, secs_left); end
        clear_board = 1'b0;
        turn_p1 = 1'b1;
        turn_p2 = 1'b0;
        tick;
        for (int k = 1; k <= 11; k++) tick;
        cell_sel = 4'd0;
        confirm  = 1'b1;
        tick;
        checks++; if (secs_left !== 4'd0) begin errors++; $display("FAIL exp_secs got %0d want 0", secs_left); end
        tick;
        checks++; if (player_mov !== 1'b1 || timer_out !== 1'b0 || board !== 18'h00001) begin errors++; $display("FAIL exp_commit got pm=%b to=%b board=%h want pm=1 to=0 board=%h", player_mov, timer_out, board, 18'h00001); end
        confirm = 1'b0;
        tick;
        checks++; if (player_mov !== 1'b0 || timer_out !== 1'b0) begin errors++; $display("FAIL exp_after got pm=%b to=%b want 0/0", player_mov, timer_out); end
        $display("test_confirm_on_expiry done");
    endtask

    task automatic test_clear_during_commit;
        turn_p1 = 1'b0;
        turn_p2 = 1'b1;
        tick;
        cell_sel = 4'd2;
        confirm  = 1'b1;
        tick;
        clear_board = 1'b1;
        confirm     = 1'b0;
        tick;
        checks++; if (board !== 18'h0 || player_mov !== 1'b0 || secs_left !== 4'd0) begin errors++; $display("FAIL clr_commit got board=%h pm=%b secs=%0d want 0/0/0", board, player_mov, secs_left); end
        clear_board = 1'b0;
        turn_p1 = 1'b1;
        tick;
        tick;
        checks++; if (secs_left !== 4'd0 || {player_mov, timer_out} !== 2'b00) begin errors++; $display("FAIL both_high got secs=%0d pulses=%b want 0/00", secs_left, {player_mov, timer_out}); end
        turn_p2 = 1'b0;
        tick;
        checks++; if (secs_left !== 4'd3) begin errors++; $display("FAIL leave_idle got %0d want 3", secs_left); end
        turn_p1 = 1'b0;
        tick;
        checks++; if (secs_left !== 4'd0 || {player_mov, timer_out, move_err} !== 3'b000) begin errors++; $display("FAIL drop_active got secs=%0d pulses=%b want 0/000", secs_left, {player_mov, timer_out, move_err}); end
        $display("test_clear_during_commit done");
    endtask

    task automatic test_reset_mid_turn;
        turn_p1 = 1'b1;
        tick;
        cell_sel = 4'd5;
        confirm  = 1'b1;
        tick;
        rst     = 1'b0;
        confirm = 1'b0;
        tick;
        checks++; if (board !== 18'h0 || player_mov !== 1'b0 || secs_left !== 4'd0) begin errors++; $display("FAIL rst_mid got board=%h pm=%b secs=%0d want 0/0/0", board, player_mov, secs_left); end
        rst     = 1'b1;
        turn_p1 = 1'b0;
        tick;
        checks++; if (board !== 18'h0 || player_mov !== 1'b0) begin errors++; $display("FAIL rst_after got board=%h pm=%b want 0/0", board, player_mov); end
        $display("test_reset_mid_turn done");
    endtask

    initial begin
        test_reset;
        test_commit;
        test_move_err;
        test_back_to_back;
        test_timeout;
        test_full_board;
        test_confirm_on_expiry;
        test_clear_during_commit;
        test_reset_mid_turn;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/turn_move_sequencer.md
Name: turn_move_sequencer

Overview:
- Per-turn controller between the game FSM and the board storage.
- Owns the 3x3 board register and the per-turn countdown.
- Accepts a player's cell selection plus confirm, or auto-places on timeout.
- Emits the single-cycle player_mov / timer_out pulses that drive the game FSM's turn change.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per second (prescaler reload = CLK_HZ-1)
- TURN_SECONDS, 10, seconds allowed per turn (1..15)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is synchronous and active-low
- turn_p1  input  1  game FSM is in PLAYER_1
- turn_p2  input  1  game FSM is in PLAYER_2
- cell_sel  input  4  selected cell index, 0..8 valid
- confirm  input  1  debounced confirm level; rising edge detected internally
- clear_board  input  1  synchronous board clear
- board  output  18  cell i = board[2i+1:2i]; 00 empty, 01 P1, 10 P2
- player_mov  output  1  one-cycle pulse: valid manual move committed
- timer_out  output  1  one-cycle pulse: turn expired (auto-place attempted)
- move_err  output  1  one-cycle pulse: confirm on occupied or out-of-range cell
- secs_left  output  4  seconds remaining in the current turn

Behaviour:
- Reset (rst low at a clk edge) clears board, player_mov, timer_out, move_err, secs_left, the confirm edge register and the latched owner, and sets state IDLE.
- active = turn_p1 XOR turn_p2. Both high counts as inactive.
- owner = P1 if turn_p1, else P2. It is latched on ARMED entry.
- All outputs are registered. player_mov, timer_out and move_err are never high for more than one cycle.
- At most one of player_mov/timer_out is asserted per turn.
- States:
  - IDLE: prescaler and secs_left held at 0. When active, go to ARMED: load prescaler=CLK_HZ-1, secs_left=TURN_SECONDS, latch owner.
  - ARMED:
    - The prescaler decrements every cycle. At 0 it reloads and secs_left decrements.
    - When prescaler==0 and secs_left==1: secs_left becomes 0, go to AUTO.
    - Confirm rising edge with cell_sel<=8 and that cell empty: go to COMMIT, latch cell_sel.
    - Confirm rising edge otherwise: move_err pulses the next cycle, stay in ARMED, timer keeps running.
    - A valid confirm edge in the same cycle as expiry wins, so go to COMMIT.
    - If active drops (game reached WIN/DRAW): go to IDLE with no write and no pulse.
  - COMMIT: write owner code into the latched cell, set player_mov, go to DONE.
    - Timing: confirm edge sampled in cycle N, COMMIT in N+1, board updated and player_mov high in N+2.
  - AUTO: write owner into the lowest-index empty cell, set timer_out, go to DONE.
    - If no cell is empty, timer_out still pulses and the board is unchanged.
  - DONE: secs_left holds.
    - Active with owner different from the latched one: go to ARMED with full reload.
    - Inactive: go to IDLE.
    - Same owner still active: wait.
- clear_board has priority over any write in the same cycle.
  - Board becomes all 00; state goes to IDLE; pending pulses are suppressed.
  - secs_left resets to 0.
- cell_sel values 9..15 never write the board.
- Reset mid-turn aborts with no pulse.

Decomposition:
- Shared package game_pkg holds:
  - cell_t enum: EMPTY=2'b00, P1=2'b01, P2=2'b10
  - seq_state_t enum: IDLE, ARMED, COMMIT, AUTO, DONE
  - constant NUM_CELLS=9
- Sub-module turn_timer holds the prescaler and seconds down-counter.
  - Inputs: load, run.
  - Outputs: secs_left, expire. expire is a one-cycle strobe when the count reaches 0.
- The free-cell priority encoder stays as a function inside turn_move_sequencer.

Test Plan (CLK_HZ=4, TURN_SECONDS=3, so 12 cycles per turn):
1. Hold rst=0 for 2 cycles, then release with turn_p1=1 -> state ARMED next cycle, secs_left=3, board=0, all pulses 0.
2. turn_p1=1, cell_sel=4, confirm rising -> two cycles later board[9:8]=01 and player_mov=1 for exactly one cycle; then drop turn_p1 and raise turn_p2 -> secs_left reloads to 3.
3. turn_p2 active, confirm on cell 4 (occupied) -> move_err one cycle, board unchanged, secs_left keeps counting; then cell_sel=12 with confirm -> move_err again.
4. turn_p2 active with no confirm for 12 cycles, cells 0 and 1 occupied -> secs_left 3,2,1,0; then board[5:4]=10, timer_out=1 for one cycle, player_mov=0.
5. Board full, timeout -> timer_out pulses, board unchanged. Valid confirm on the expiry cycle -> player_mov only, no timer_out.
6. clear_board=1 during COMMIT -> board=0 next cycle, no player_mov, state IDLE. turn_p1 and turn_p2 both high -> stays IDLE, secs_left=0.
